regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, tie policy (1 = round-robin, 0 = fixed load priority).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iss_valid  input  1  load issued this cycle; marks iss_rd as pending.
REQ-006 iss_rd  input  5  destination register of the issued load.
REQ-007 alu_valid  input  1  ALU writeback request.
REQ-008 alu_rd  input  5  ALU destination register.
REQ-009 alu_data  input  32  ALU result.
REQ-010 alu_ready  output  1  ALU request granted this cycle.
REQ-011 ld_valid  input  1  load writeback request.
REQ-012 ld_rd  input  5  load destination register.
REQ-013 ld_data  input  32  load data.
REQ-014 ld_ready  output  1  load request granted this cycle.
REQ-015 rs1  input  5  decode source register 1.
REQ-016 rs2  input  5  decode source register 2.
REQ-017 stall  output  1  decode must hold.
REQ-018 busy  output  32  per-register pending-load bitmap.
REQ-019 RegWEn  output  1  register-file write enable, registered.
REQ-020 AddrD  output  5  register-file write address, registered.
REQ-021 DataD  output  32  register-file write data, registered.

Function
REQ-022 Handshake: a transfer occurs when valid and ready are both high in the same cycle; a requester SHALL hold valid, rd and data stable until ready.
REQ-023 Grant: at most one of alu_ready/ld_ready is high per cycle; ready is combinational from the valids and the last_grant flop, never from data.
REQ-024 Single request: the lone valid requester is granted in the same cycle.
REQ-025 Tie, RR_EN=1: the requester not granted most recently wins; last_grant updates only on a transfer.
REQ-026 Tie, RR_EN=0: load always wins; the ALU waits.
REQ-027 Latency: a transfer in cycle N drives RegWEn=1, AddrD=rd, DataD=data in cycle N+1; with no transfer, RegWEn=0 in cycle N+1 and AddrD/DataD hold their previous values.
REQ-028 x0: a transfer with rd=0 completes the handshake but produces RegWEn=0.
REQ-029 Scoreboard set: iss_valid with iss_rd!=0 sets busy[iss_rd] at the next edge; iss_rd=0 is ignored.
REQ-030 Scoreboard clear: a load transfer clears busy[ld_rd] at the next edge; ALU transfers never change busy.
REQ-031 Simultaneous set and clear of the same register in one cycle: the set wins and busy stays 1.
REQ-032 stall = busy[rs1] | busy[rs2] | (RegWEn & AddrD!=0 & (AddrD==rs1 | AddrD==rs2)); combinational, with no cycle of delay.
REQ-033 busy[0] is always 0.

Reset
REQ-034 While reset=1 at an edge: RegWEn=0, AddrD=0, DataD=0, busy=0, last_grant=ALU (the first tie goes to load).
REQ-035 Reset mid-operation: pending busy bits and any registered write are discarded; RegWEn is 0 in the cycle after reset.
REQ-036 While reset is asserted, alu_ready and ld_ready are 0 and no transfer occurs.

Structure
REQ-037 The shared package holds XLEN=32, REG_ADDR_W=5, and the grant encoding GNT_ALU=0, GNT_LD=1.
REQ-038 One sub-module, rr_arb2 (2-way round-robin arbiter with a fixed-priority mode), holds the grant logic and last_grant; the scoreboard and output registers stay in the top module.

Verification
REQ-039 Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 in the same cycle; next cycle RegWEn=1, AddrD=5, DataD=0xDEADBEEF.
REQ-040 RR_EN=1, both valid for 3 cycles with distinct rd -> grant order LD, ALU, LD; RegWEn=1 in each following cycle.
REQ-041 iss_valid=1, iss_rd=7; then rs1=7 -> busy[7]=1 and stall=1; ld_valid with ld_rd=7 transfers -> busy[7]=0 after the edge, RegWEn=1 with AddrD=7, then stall drops once the write retires.
REQ-042 Same cycle: iss_rd=9 and a load transfer with ld_rd=9 -> busy[9] stays 1.
REQ-043 alu_rd=0 transfer and iss_rd=0 -> alu_ready=1, RegWEn=0 next cycle, busy=0.
REQ-044 reset asserted with busy=0x0000_00F0 and RegWEn=1 -> after the edge busy=0, RegWEn=0, and the next tie grants load.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and grant encoding for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   localparam logic GNT_ALU = 1'b0;
   localparam logic GNT_LD  = 1'b1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way writeback arbiter: round-robin on ties, or fixed load priority when RR_EN=0.
module rr_arb2
   import regfile_wb_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic alu_valid_i,
   input  logic ld_valid_i,
   output logic alu_gnt_o,
   output logic ld_gnt_o
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      alu_gnt_o = 1'b0;
      ld_gnt_o  = 1'b0;
      if (!reset_i) begin
         if (alu_valid_i && ld_valid_i) begin
            // On a tie the side that did not win last time goes first.
            if (RR_EN && (last_grant_q == GNT_LD)) begin
               alu_gnt_o = 1'b1;
            end else begin
               ld_gnt_o = 1'b1;
            end
         end else begin
            alu_gnt_o = alu_valid_i;
            ld_gnt_o  = ld_valid_i;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (ld_gnt_o) begin
         last_grant_d = GNT_LD;
      end else if (alu_gnt_o) begin
         last_grant_d = GNT_ALU;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_grant_q <= GNT_ALU;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks into one registered register-file write port
// and tracks in-flight load destinations to generate the decode stall.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   output logic                  alu_ready,
   input  logic                  ld_valid,
   input  logic [REG_ADDR_W-1:0] ld_rd,
   input  logic [XLEN-1:0]       ld_data,
   output logic                  ld_ready,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   output logic                  stall,
   output logic [NUM_REGS-1:0]   busy,
   output logic                  RegWEn,
   output logic [REG_ADDR_W-1:0] AddrD,
   output logic [XLEN-1:0]       DataD
);

   logic                  alu_xfer;
   logic                  ld_xfer;
   logic [REG_ADDR_W-1:0] wr_rd;
   logic [XLEN-1:0]       wr_data;

   logic [NUM_REGS-1:0]   busy_q,   busy_d;
   logic                  regwen_q, regwen_d;
   logic [REG_ADDR_W-1:0] addrd_q,  addrd_d;
   logic [XLEN-1:0]       datad_q,  datad_d;

   rr_arb2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk_i       (clk),
      .reset_i     (reset),
      .alu_valid_i (alu_valid),
      .ld_valid_i  (ld_valid),
      .alu_gnt_o   (alu_ready),
      .ld_gnt_o    (ld_ready)
   );

   assign alu_xfer = alu_valid & alu_ready;
   assign ld_xfer  = ld_valid & ld_ready;
   assign wr_rd    = ld_xfer ? ld_rd   : alu_rd;
   assign wr_data  = ld_xfer ? ld_data : alu_data;

   always_comb begin
      regwen_d = 1'b0;
      addrd_d  = addrd_q;
      datad_d  = datad_q;
      if (alu_xfer || ld_xfer) begin
         // x0 writes still complete the handshake but never reach the file.
         regwen_d = (wr_rd != '0);
         addrd_d  = wr_rd;
         datad_d  = wr_data;
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (ld_xfer) begin
         busy_d[ld_rd] = 1'b0;
      end
      // Set after clear so a same-cycle reissue of the register stays pending.
      if (iss_valid && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q   <= '0;
         regwen_q <= 1'b0;
         addrd_q  <= '0;
         datad_q  <= '0;
      end else begin
         busy_q   <= busy_d;
         regwen_q <= regwen_d;
         addrd_q  <= addrd_d;
         datad_q  <= datad_d;
      end
   end

   assign busy   = busy_q;
   assign RegWEn = regwen_q;
   assign AddrD  = addrd_q;
   assign DataD  = datad_q;

   assign stall = busy_q[rs1] | busy_q[rs2] |
                  (regwen_q & (addrd_q != '0) & ((addrd_q == rs1) | (addrd_q == rs2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grant order, writeback latency, scoreboard, reset.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic [31:0] busy;
  logic        RegWEn;
  logic [4:0]  AddrD;
  logic [31:0] DataD;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.RR_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .stall     (stall),
    .busy      (busy),
    .RegWEn    (RegWEn),
    .AddrD     (AddrD),
    .DataD     (DataD)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b1; alu_rd = rd; alu_data = data;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [31:0] data);
    ld_valid = 1'b1; ld_rd = rd; ld_data = data;
  endtask

  task automatic drive_iss(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // requests during reset must not be granted
    drive_alu(5'd1, 32'h1111_1111);
    drive_ld(5'd2, 32'h2222_2222);
    drive_iss(5'd3);
    tick();
    tick();
    chk("rst_regwen", {31'd0, RegWEn}, 32'd0);
    chk("rst_addrd", {27'd0, AddrD}, 32'd0);
    chk("rst_datad", DataD, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);

    // single ALU request: same-cycle grant, one-cycle write latency
    idle();
    reset = 1'b0;
    drive_alu(5'd5, 32'hDEAD_BEEF);
    settle();
    chk("single_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("single_ld_ready", {31'd0, ld_ready}, 32'd0);
    tick();
    chk("single_regwen", {31'd0, RegWEn}, 32'd1);
    chk("single_addrd", {27'd0, AddrD}, 32'd5);
    chk("single_datad", DataD, 32'hDEAD_BEEF);

    // round-robin tie: LD, ALU, LD
    idle();
    drive_alu(5'd1, 32'hA1A1_A1A1);
    drive_ld(5'd2, 32'hB2B2_B2B2);
    settle();
    chk("tie1_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("tie1_alu_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    chk("tie1_regwen", {31'd0, RegWEn}, 32'd1);
    chk("tie1_addrd", {27'd0, AddrD}, 32'd2);
    chk("tie1_datad", DataD, 32'hB2B2_B2B2);
    drive_ld(5'd3, 32'hC3C3_C3C3);
    settle();
    chk("tie2_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("tie2_ld_ready", {31'd0, ld_ready}, 32'd0);
    tick();
    chk("tie2_regwen", {31'd0, RegWEn}, 32'd1);
    chk("tie2_addrd", {27'd0, AddrD}, 32'd1);
    chk("tie2_datad", DataD, 32'hA1A1_A1A1);
    drive_alu(5'd4, 32'hD4D4_D4D4);
    settle();
    chk("tie3_ld_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    chk("tie3_regwen", {31'd0, RegWEn}, 32'd1);
    chk("tie3_addrd", {27'd0, AddrD}, 32'd3);
    chk("tie3_datad", DataD, 32'hC3C3_C3C3);

    // no transfer: write enable drops, address/data hold
    idle();
    tick();
    chk("idle_regwen", {31'd0, RegWEn}, 32'd0);
    chk("idle_addrd", {27'd0, AddrD}, 32'd3);
    chk("idle_datad", DataD, 32'hC3C3_C3C3);

    // pending load on x7 stalls decode until its write retires
    drive_iss(5'd7);
    tick();
    idle();
    rs1 = 5'd7;
    settle();
    chk("iss7_busy", busy, 32'h0000_0080);
    chk("iss7_stall", {31'd0, stall}, 32'd1);
    drive_ld(5'd7, 32'h7777_7777);
    settle();
    chk("ld7_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    chk("ld7_busy", busy, 32'd0);
    chk("ld7_regwen", {31'd0, RegWEn}, 32'd1);
    chk("ld7_addrd", {27'd0, AddrD}, 32'd7);
    chk("ld7_stall_bypass", {31'd0, stall}, 32'd1);
    ld_valid = 1'b0;
    tick();
    chk("ld7_stall_clear", {31'd0, stall}, 32'd0);

    // same-cycle issue and load completion on x9: set wins
    idle();
    drive_iss(5'd9);
    drive_ld(5'd9, 32'h9999_9999);
    tick();
    chk("x9_set_wins", busy, 32'h0000_0200);
    idle();
    drive_ld(5'd9, 32'h9999_0000);
    tick();
    chk("x9_cleared", busy, 32'd0);

    // ALU writes never clear the scoreboard; stall via rs2
    idle();
    drive_iss(5'd3);
    tick();
    idle();
    drive_alu(5'd3, 32'h3333_3333);
    tick();
    idle();
    rs2 = 5'd3;
    settle();
    chk("alu3_busy_kept", busy, 32'h0000_0008);
    chk("alu3_regwen", {31'd0, RegWEn}, 32'd1);
    chk("alu3_stall_rs2", {31'd0, stall}, 32'd1);
    idle();
    drive_ld(5'd3, 32'h0);
    tick();
    chk("x3_cleared", busy, 32'd0);

    // x0 writes handshake but do not write; x0 issue ignored
    idle();
    drive_alu(5'd0, 32'h0000_1234);
    drive_iss(5'd0);
    settle();
    chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    chk("x0_regwen", {31'd0, RegWEn}, 32'd0);
    chk("x0_busy", busy, 32'd0);

    // build busy=0xF0, last transfer a load, then reset mid-operation
    idle();
    drive_iss(5'd4);
    tick();
    drive_iss(5'd5);
    tick();
    drive_iss(5'd6);
    tick();
    drive_iss(5'd7);
    drive_ld(5'd10, 32'hAAAA_0000);
    tick();
    chk("pre_rst_busy", busy, 32'h0000_00F0);
    chk("pre_rst_regwen", {31'd0, RegWEn}, 32'd1);
    idle();
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_regwen", {31'd0, RegWEn}, 32'd0);
    chk("mid_rst_addrd", {27'd0, AddrD}, 32'd0);
    reset = 1'b0;
    drive_alu(5'd11, 32'hBBBB_0000);
    drive_ld(5'd12, 32'hCCCC_0000);
    settle();
    chk("post_rst_tie_ld", {31'd0, ld_ready}, 32'd1);
    chk("post_rst_tie_alu", {31'd0, alu_ready}, 32'd0);
    tick();
    chk("post_rst_addrd", {27'd0, AddrD}, 32'd12);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
